// File: rtl/pulse_stretcher_if.sv
// Trigger/status bundle between a pulse source and pulse_stretcher.
// The master drives the trigger and clear; the slave returns the stretched level and queue status.
interface pulse_stretcher_if #(
  parameter int PEND_W = 3
) ();
  logic              in_pulse;
  logic              clr;
  logic              out_level;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output in_pulse,
    output clr,
    input  out_level,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  in_pulse,
    input  clr,
    output out_level,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle trigger pulses into HIGH_CYCLES-wide windows followed by a GAP_CYCLES low guard.
// Pulses arriving while busy are queued in a saturating counter and replayed back to back.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_stretcher_if.slave   bus
);

  localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [PEND_W-1:0] pending_q,  pending_d;
  logic              overflow_q, overflow_d;
  logic              out_level_q, out_level_d;
  logic              busy_q,     busy_d;

  // A pulse that arrives mid-window is queued; at the ceiling it is lost and flagged.
  logic [PEND_W-1:0] pend_inc;
  logic              pend_lost;

  always_comb begin
    pend_inc  = pending_q;
    pend_lost = 1'b0;
    if (bus.in_pulse) begin
      if (pending_q == PEND_MAX) begin
        pend_lost = 1'b1;
      end else begin
        pend_inc = pending_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      out_level_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      out_level_q <= out_level_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (bus.clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      pending_d  = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_pulse) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
          end
        end

        HIGH: begin
          pending_d  = pend_inc;
          overflow_d = overflow_q | pend_lost;
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        GAP: begin
          if (cnt_q == '0) begin
            // Final gap edge: a live pulse is served directly, so the queue
            // depth is unchanged; otherwise one queued pulse is consumed.
            if (bus.in_pulse) begin
              state_d = HIGH;
              cnt_d   = HIGH_LOAD;
            end else if (pending_q != '0) begin
              state_d   = HIGH;
              cnt_d     = HIGH_LOAD;
              pending_d = pending_q - 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d      = cnt_q - 1'b1;
            pending_d  = pend_inc;
            overflow_d = overflow_q | pend_lost;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    out_level_d = (state_d == HIGH);
    busy_d      = (state_d != IDLE);
  end

  assign bus.out_level = out_level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule
